// File: rtl/prra_pkg.sv
// Shared helpers and default sizing for the prra round-robin arbiter family.
package prra_pkg;

    localparam int DEF_WIDTH        = 4;
    localparam int DEF_WEIGHT_WIDTH = 4;

    // Ceiling log2, usable in parameter defaults.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Index of the set bit of a one-hot vector (0 when all-zero).
    function automatic int onehot_to_idx(input logic [31:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if (oh[i]) r = i;
        return r;
    endfunction

endpackage

// File: rtl/prra_pick.sv
// Combinational rotating-priority picker: searches start+1, start+2, ...
// wrapping modulo WIDTH and ending at start itself; first requester wins.
module prra_pick
    import prra_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LOG2_WIDTH = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]      request,
    input  logic [LOG2_WIDTH-1:0] start,
    output logic [WIDTH-1:0]      gnt,
    output logic [LOG2_WIDTH-1:0] idx,
    output logic                  found
);

    int c;

    // Walk the ring once starting just after the previous owner.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 1; k <= WIDTH; k++) begin
            c = (int'(start) + k) % WIDTH;
            if (!found && request[c]) begin
                gnt[c] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign idx = LOG2_WIDTH'(onehot_to_idx(32'(gnt)));

endmodule

// File: rtl/prra_quota.sv
// Round-robin arbiter with grant locking and optional per-channel hold quota.
// Define PRRA_QUOTA_EN to compile in the quota counter; without it the owner
// holds until its request drops and the weight port is ignored.
// PIPELINE adds register stages on grant/state/grant_valid only.
module prra_quota
    import prra_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int LOG2_WIDTH   = clog2(WIDTH),
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int PIPELINE     = 0
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic [WIDTH-1:0]              request,
    input  logic [WIDTH*WEIGHT_WIDTH-1:0] weight,
    output logic [LOG2_WIDTH-1:0]         state,
    output logic [WIDTH-1:0]              grant,
    output logic                          grant_valid
);

    localparam logic [LOG2_WIDTH-1:0] OWN_RST = LOG2_WIDTH'(WIDTH - 1);

    logic [LOG2_WIDTH-1:0] own;
    logic [WIDTH-1:0]      g;
    logic [WIDTH-1:0]      pk_gnt;
    logic [LOG2_WIDTH-1:0] pk_idx;
    logic                  pk_found;
    logic                  hold;

    prra_pick #(
        .WIDTH      (WIDTH),
        .LOG2_WIDTH (LOG2_WIDTH)
    ) u_pick (
        .request (request),
        .start   (own),
        .gnt     (pk_gnt),
        .idx     (pk_idx),
        .found   (pk_found)
    );

`ifdef PRRA_QUOTA_EN
    logic [WEIGHT_WIDTH-1:0] qc;
    logic [WEIGHT_WIDTH-1:0] pick_w;

    // qc==1 can only occur with a non-zero sampled weight, so it alone marks
    // an exhausted quota; qc==0 means unlimited hold.
    assign pick_w = weight[pk_idx*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign hold   = g[own] && request[own] && (qc != WEIGHT_WIDTH'(1));

    // Quota counter: reload on every new grant (including a re-grant to a
    // sole requester at quota), count down while held, never underflow.
    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            qc <= '0;
        else if (hold) begin
            if (qc != '0) qc <= qc - WEIGHT_WIDTH'(1);
        end else if (pk_found)
            qc <= pick_w;
    end
`else
    logic unused_weight;
    assign unused_weight = ^weight;
    assign hold          = g[own] && request[own];
`endif

    // Core arbitration: hold, rotate from the owner, or idle keeping the owner.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            own <= OWN_RST;
            g   <= '0;
        end else if (!hold) begin
            if (pk_found) begin
                g   <= pk_gnt;
                own <= pk_idx;
            end else
                g <= '0;
        end
    end

    generate
        if (PIPELINE == 0) begin : g_nopipe
            assign grant       = g;
            assign state       = own;
            assign grant_valid = |g;
        end else begin : g_pipe
            logic [PIPELINE:1][WIDTH-1:0]      g_pipe;
            logic [PIPELINE:1][LOG2_WIDTH-1:0] st_pipe;
            logic [PIPELINE:1]                 vld_pipe;

            // Output delay line; grant, state and valid move together.
            always_ff @(posedge clk or posedge arst) begin
                if (arst) begin
                    g_pipe   <= '0;
                    st_pipe  <= {PIPELINE{OWN_RST}};
                    vld_pipe <= '0;
                end else begin
                    g_pipe[1]   <= g;
                    st_pipe[1]  <= own;
                    vld_pipe[1] <= |g;
                    for (int s = 2; s <= PIPELINE; s++) begin
                        g_pipe[s]   <= g_pipe[s-1];
                        st_pipe[s]  <= st_pipe[s-1];
                        vld_pipe[s] <= vld_pipe[s-1];
                    end
                end
            end

            assign grant       = g_pipe[PIPELINE];
            assign state       = st_pipe[PIPELINE];
            assign grant_valid = vld_pipe[PIPELINE];
        end
    endgenerate

endmodule

// File: tb/tb_prra_quota.sv
// Directed bench for prra_quota (WIDTH=4): lock/release, idle memory, quota
// rotation, sole requester at quota, async reset mid-hold, PIPELINE=2 latency.
module tb_prra_quota;

    logic        clk;
    logic        arst;
    logic [3:0]  request, request2;
    logic [15:0] weight;
    logic [1:0]  state, state2;
    logic [3:0]  grant, grant2;
    logic        grant_valid, grant_valid2;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] g;
        logic [1:0] st;
        logic       v;
    } vec_t;

    prra_quota #(.WIDTH(4), .LOG2_WIDTH(2), .WEIGHT_WIDTH(4), .PIPELINE(0)) u_dut (
        .clk(clk), .arst(arst), .request(request), .weight(weight),
        .state(state), .grant(grant), .grant_valid(grant_valid));

    prra_quota #(.WIDTH(4), .LOG2_WIDTH(2), .WEIGHT_WIDTH(4), .PIPELINE(2)) u_pipe (
        .clk(clk), .arst(arst), .request(request2), .weight(16'h0000),
        .state(state2), .grant(grant2), .grant_valid(grant_valid2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        arst     = 1'b1;
        request  = '0;
        request2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
    endtask

    // Apply a request for one edge, then sample 1 time unit after it.
    task automatic step(input logic [3:0] r);
        request = r;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        step(v.req);
        chk({tag, ".grant"}, 32'(grant), 32'(v.g));
        chk({tag, ".state"}, 32'(state), 32'(v.st));
        chk({tag, ".valid"}, 32'(grant_valid), 32'(v.v));
    endtask

    vec_t       lr[8];
    logic [3:0] qseq[9];

    initial begin
        // Lock/release then idle memory, weights 0 (unlimited).
        lr[0] = '{4'b0100, 4'b0100, 2'd2, 1'b1};
        lr[1] = '{4'b0110, 4'b0100, 2'd2, 1'b1};
        lr[2] = '{4'b0010, 4'b0010, 2'd1, 1'b1};
        lr[3] = '{4'b0111, 4'b0010, 2'd1, 1'b1};
        lr[4] = '{4'b0101, 4'b0100, 2'd2, 1'b1};
        lr[5] = '{4'b0010, 4'b0010, 2'd1, 1'b1};
        lr[6] = '{4'b0000, 4'b0000, 2'd1, 1'b0};
        lr[7] = '{4'b1111, 4'b0100, 2'd2, 1'b1};
`ifdef PRRA_QUOTA_EN
        qseq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                 4'b0100, 4'b1000, 4'b1000, 4'b0001};
`else
        qseq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif

        weight = 16'h0000;
        do_reset();
        chk("rst.grant", 32'(grant), 32'h0);
        chk("rst.valid", 32'(grant_valid), 32'h0);
        chk("rst.state", 32'(state), 32'h3);
        chk("rst.pipe_state", 32'(state2), 32'h3);
        chk("rst.pipe_valid", 32'(grant_valid2), 32'h0);

        for (int i = 0; i < 8; i++)
            run_vec($sformatf("lock%0d", i), lr[i]);

        // Quota rotation: all weights 2, all requesting.
        weight = 16'h2222;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(4'b1111);
            chk($sformatf("quota%0d.grant", i), 32'(grant), 32'(qseq[i]));
        end

        // Sole requester at quota: never a bubble.
        weight = 16'h0001;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(4'b0001);
            chk($sformatf("sole%0d.grant", i), 32'(grant), 32'h1);
            chk($sformatf("sole%0d.valid", i), 32'(grant_valid), 32'h1);
        end

        // Asynchronous reset between edges while channel 3 holds.
        weight = 16'h0000;
        do_reset();
        step(4'b1000);
        step(4'b1000);
        chk("hold3.grant", 32'(grant), 32'h8);
        #2 arst = 1'b1;
        #1;
        chk("arst.grant", 32'(grant), 32'h0);
        chk("arst.state", 32'(state), 32'h3);
        chk("arst.valid", 32'(grant_valid), 32'h0);
        @(negedge clk);
        arst = 1'b0;
        step(4'b1111);
        chk("post_arst.grant", 32'(grant), 32'h1);

        // PIPELINE=2: three edges from request to grant and to release.
        do_reset();
        request2 = 4'b0100;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("pipe_on%0d.grant", i), 32'(grant2), (i == 3) ? 32'h4 : 32'h0);
            chk($sformatf("pipe_on%0d.valid", i), 32'(grant_valid2), (i == 3) ? 32'h1 : 32'h0);
        end
        chk("pipe_on.state", 32'(state2), 32'h2);
        request2 = 4'b0000;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("pipe_off%0d.grant", i), 32'(grant2), (i == 3) ? 32'h0 : 32'h4);
        end
        chk("pipe_off.state", 32'(state2), 32'h2);
        chk("pipe_off.valid", 32'(grant_valid2), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
